// File: rtl/proc_clk_ctrl.sv
// proc_clk_ctrl: run/halt/single-step controller that divides the board clock into a
// glitch-free processor clock, with rate changes deferred to phase boundaries.
`default_nettype none

module proc_clk_ctrl #(
  parameter int CNT_W = 26,
  parameter int DIV_0 = 25,
  parameter int DIV_1 = 25000,
  parameter int DIV_2 = 2500000,
  parameter int DIV_3 = 12500000
) (
  input  logic       clkIn,
  input  logic       rst,
  input  logic       run_req,
  input  logic       halt_req,
  input  logic       step_req,
  input  logic       rate_req,
  input  logic [1:0] rate_sel,
  output logic       rate_ack,
  output logic       clkOut,
  output logic       tick,
  output logic [1:0] state,
  output logic       busy
);

  localparam logic [CNT_W-1:0] LIM_0 = CNT_W'(DIV_0 - 1);
  localparam logic [CNT_W-1:0] LIM_1 = CNT_W'(DIV_1 - 1);
  localparam logic [CNT_W-1:0] LIM_2 = CNT_W'(DIV_2 - 1);
  localparam logic [CNT_W-1:0] LIM_3 = CNT_W'(DIV_3 - 1);

  typedef enum logic [1:0] {
    ST_HALT = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2
  } state_t;

  state_t           st, st_nxt;
  logic [CNT_W-1:0] count, count_nxt;
  logic [CNT_W-1:0] lim;
  logic             at_lim;
  logic             clk_q, clk_nxt;
  logic             tick_q, tick_nxt;
  logic             ack_q, ack_nxt;
  logic             busy_q, busy_nxt;
  logic [1:0]       active_rate, rate_nxt;
  logic             pend_valid, pend_nxt;
  logic [1:0]       pend_rate, pend_rate_nxt;
  logic             halt_lat, halt_lat_nxt;
  logic             apply;

  always_comb begin
    lim = LIM_0;
    case (active_rate)
      2'd0:    lim = LIM_0;
      2'd1:    lim = LIM_1;
      2'd2:    lim = LIM_2;
      default: lim = LIM_3;
    endcase
  end

  assign at_lim = (count == lim);

  always_comb begin
    st_nxt        = st;
    count_nxt     = count;
    clk_nxt       = clk_q;
    tick_nxt      = 1'b0;
    ack_nxt       = 1'b0;
    rate_nxt      = active_rate;
    pend_nxt      = pend_valid;
    pend_rate_nxt = pend_rate;
    halt_lat_nxt  = halt_lat;
    apply         = 1'b0;

    case (st)
      ST_HALT: begin
        count_nxt    = '0;
        clk_nxt      = 1'b0;
        halt_lat_nxt = 1'b0;
        apply        = pend_valid;
        if (halt_req)      st_nxt = ST_HALT;
        else if (step_req) st_nxt = ST_STEP;
        else if (run_req)  st_nxt = ST_RUN;
      end

      ST_RUN, ST_STEP: begin
        if (st == ST_RUN && halt_req && !clk_q) begin
          // Low phase may be cut short: no edge reaches the core.
          st_nxt    = ST_HALT;
          count_nxt = '0;
        end else if (at_lim) begin
          count_nxt = '0;
          clk_nxt   = ~clk_q;
          if (!clk_q) begin
            tick_nxt = 1'b1;
          end else begin
            // Falling boundary: the only safe point for rate changes and stopping.
            apply = pend_valid;
            if (st == ST_STEP || halt_lat || halt_req) begin
              st_nxt       = ST_HALT;
              halt_lat_nxt = 1'b0;
            end
          end
        end else begin
          count_nxt = count + 1'b1;
          if (st == ST_RUN && halt_req) halt_lat_nxt = 1'b1;
        end
      end

      default: begin
        st_nxt       = ST_HALT;
        count_nxt    = '0;
        clk_nxt      = 1'b0;
        halt_lat_nxt = 1'b0;
      end
    endcase

    // A fresh request supersedes any apply this edge, so only one ack is issued.
    if (rate_req) begin
      pend_nxt      = 1'b1;
      pend_rate_nxt = rate_sel;
    end else if (apply) begin
      pend_nxt = 1'b0;
      rate_nxt = pend_rate;
      ack_nxt  = 1'b1;
    end

    busy_nxt = pend_nxt || (st_nxt == ST_STEP);
  end

  always_ff @(posedge clkIn or posedge rst) begin
    if (rst) begin
      st          <= ST_HALT;
      count       <= '0;
      clk_q       <= 1'b0;
      tick_q      <= 1'b0;
      ack_q       <= 1'b0;
      busy_q      <= 1'b0;
      active_rate <= 2'd0;
      pend_valid  <= 1'b0;
      pend_rate   <= 2'd0;
      halt_lat    <= 1'b0;
    end else begin
      st          <= st_nxt;
      count       <= count_nxt;
      clk_q       <= clk_nxt;
      tick_q      <= tick_nxt;
      ack_q       <= ack_nxt;
      busy_q      <= busy_nxt;
      active_rate <= rate_nxt;
      pend_valid  <= pend_nxt;
      pend_rate   <= pend_rate_nxt;
      halt_lat    <= halt_lat_nxt;
    end
  end

  assign clkOut   = clk_q;
  assign tick     = tick_q;
  assign rate_ack = ack_q;
  assign state    = st;
  assign busy     = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_proc_clk_ctrl.sv
// tb_proc_clk_ctrl: directed scenarios plus random requests, checked each cycle against
// a phase-countdown reference model of the clock controller.
`default_nettype none

module tb_proc_clk_ctrl;

  logic       clkIn = 1'b0;
  logic       rst = 1'b1;
  logic       run_req = 1'b0, halt_req = 1'b0, step_req = 1'b0, rate_req = 1'b0;
  logic [1:0] rate_sel = 2'd0;
  logic       rate_ack, clkOut, tick, busy;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;
  int tick_seen = 0, ack_seen = 0, high_seen = 0;

  // Reference model: mode 0 halt, 1 run, 2 step; left = cycles until the next toggle.
  int m_mode, m_left, m_rate, m_pend;
  bit m_level, m_tick, m_ack, m_busy, m_halt_pend;

  proc_clk_ctrl #(.CNT_W(26), .DIV_0(2), .DIV_1(3), .DIV_2(5), .DIV_3(8)) dut (
    .clkIn(clkIn), .rst(rst), .run_req(run_req), .halt_req(halt_req),
    .step_req(step_req), .rate_req(rate_req), .rate_sel(rate_sel),
    .rate_ack(rate_ack), .clkOut(clkOut), .tick(tick), .state(state), .busy(busy)
  );

  always #5 clkIn = ~clkIn;

  function automatic int half_period(input int r);
    case (r)
      0: return 2;
      1: return 3;
      2: return 5;
      default: return 8;
    endcase
  endfunction

  task automatic model_reset();
    m_mode = 0; m_left = 0; m_rate = 0; m_pend = -1;
    m_level = 0; m_tick = 0; m_ack = 0; m_busy = 0; m_halt_pend = 0;
  endtask

  task automatic model_edge(input bit rn, input bit hl, input bit sp, input bit rr, input int rs);
    bit rose, fell, was_halt, started;
    rose = 0; fell = 0; started = 0;
    was_halt = (m_mode == 0);
    if (was_halt) begin
      m_halt_pend = 0;
      if (hl) m_mode = 0;
      else if (sp) begin m_mode = 2; started = 1; end
      else if (rn) begin m_mode = 1; started = 1; end
    end else if (m_mode == 1 && hl && !m_level) begin
      m_mode = 0;
    end else begin
      if (m_mode == 1 && hl) m_halt_pend = 1;
      m_left = m_left - 1;
      if (m_left == 0) begin
        m_level = !m_level;
        rose = m_level;
        fell = !m_level;
        if (fell && (m_mode == 2 || m_halt_pend)) begin
          m_mode = 0;
          m_halt_pend = 0;
        end
      end
    end
    m_ack = 0;
    if (rr) m_pend = rs;
    else if (m_pend >= 0 && (was_halt || fell)) begin
      m_rate = m_pend; m_pend = -1; m_ack = 1;
    end
    if (m_mode == 0) m_level = 0;
    if (started || rose || fell) m_left = half_period(m_rate);
    m_tick = rose;
    m_busy = (m_pend >= 0) || (m_mode == 2);
  endtask

  task automatic check_all(input string tag);
    checks++;
    assert (clkOut === m_level) else begin
      errors++; $error("FAIL %s clkOut got %b exp %b", tag, clkOut, m_level);
    end
    checks++;
    assert (tick === m_tick) else begin
      errors++; $error("FAIL %s tick got %b exp %b", tag, tick, m_tick);
    end
    checks++;
    assert (rate_ack === m_ack) else begin
      errors++; $error("FAIL %s rate_ack got %b exp %b", tag, rate_ack, m_ack);
    end
    checks++;
    assert (state === 2'(m_mode)) else begin
      errors++; $error("FAIL %s state got %0d exp %0d", tag, state, m_mode);
    end
    checks++;
    assert (busy === m_busy) else begin
      errors++; $error("FAIL %s busy got %b exp %b", tag, busy, m_busy);
    end
  endtask

  task automatic cycle(input bit rn, input bit hl, input bit sp, input bit rr,
                       input logic [1:0] rs, input string tag);
    run_req = rn; halt_req = hl; step_req = sp; rate_req = rr; rate_sel = rs;
    @(posedge clkIn);
    model_edge(rn, hl, sp, rr, int'(rs));
    #1;
    run_req = 0; halt_req = 0; step_req = 0; rate_req = 0;
    check_all(tag);
    if (tick === 1'b1) tick_seen++;
    if (rate_ack === 1'b1) ack_seen++;
    if (clkOut === 1'b1) high_seen++;
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 2'd0, tag);
  endtask

  task automatic wait_high(input string tag);
    int n = 0;
    while (clkOut !== 1'b1 && n < 50) begin
      cycle(0, 0, 0, 0, 2'd0, tag);
      n++;
    end
    checks++;
    assert (clkOut === 1'b1) else begin
      errors++; $error("FAIL %s wait_high clkOut got %b exp 1", tag, clkOut);
    end
  endtask

  // Reset is raised mid-cycle to exercise its asynchronous path.
  task automatic do_reset(input string tag);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all({tag, "_async"});
    @(posedge clkIn);
    #1;
    check_all({tag, "_held"});
    rst = 1'b0;
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clkIn);
    #1;
    check_all("reset");
    rst = 1'b0;

    // 1: run at rate 0
    cycle(1, 0, 0, 0, 2'd0, "s1_run");
    tick_seen = 0;
    idle(12, "s1_free");
    checks++;
    assert (tick_seen === 3) else begin
      errors++; $error("FAIL s1_ticks got %0d exp 3", tick_seen);
    end

    // 2: halt one cycle into a high phase
    wait_high("s2_wait");
    cycle(0, 1, 0, 0, 2'd0, "s2_halt");
    high_seen = 0;
    idle(22, "s2_hold");
    checks++;
    assert (high_seen === 0) else begin
      errors++; $error("FAIL s2_low_hold high cycles got %0d exp 0", high_seen);
    end

    // 3: single step at rate 1
    cycle(0, 0, 0, 1, 2'd1, "s3_rate");
    idle(1, "s3_apply");
    tick_seen = 0; high_seen = 0;
    cycle(0, 0, 1, 0, 2'd0, "s3_step");
    idle(10, "s3_body");
    checks++;
    assert (tick_seen === 1 && high_seen === 3) else begin
      errors++; $error("FAIL s3_step ticks %0d high %0d exp 1 and 3", tick_seen, high_seen);
    end

    // 4: rate change mid-high while running
    cycle(1, 0, 0, 0, 2'd0, "s4_run");
    wait_high("s4_wait");
    cycle(0, 0, 0, 1, 2'd3, "s4_rate");
    idle(40, "s4_slow");

    // 5: back-to-back rate requests, then simultaneous run/step/halt
    ack_seen = 0;
    cycle(0, 0, 0, 1, 2'd2, "s5_rate2");
    cycle(0, 0, 0, 1, 2'd3, "s5_rate3");
    idle(30, "s5_slow");
    checks++;
    assert (ack_seen === 1) else begin
      errors++; $error("FAIL s5_acks got %0d exp 1", ack_seen);
    end
    cycle(1, 1, 1, 0, 2'd0, "s5_all_run");
    idle(20, "s5_stop");
    cycle(1, 1, 1, 0, 2'd0, "s5_all_halt");
    idle(3, "s5_idle");

    // 6: reset mid-high with a rate pending
    cycle(1, 0, 0, 0, 2'd0, "s6_run");
    wait_high("s6_wait");
    cycle(0, 0, 0, 1, 2'd1, "s6_rate");
    do_reset("s6_rst");
    cycle(1, 0, 0, 0, 2'd0, "s6_rerun");
    idle(12, "s6_rate0");
    cycle(0, 1, 0, 0, 2'd0, "s6_halt");
    idle(10, "s6_drain");

    // Random requests with occasional resets
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset("rnd_rst");
      end else begin
        cycle($urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0,
              $urandom_range(0, 14) == 0, $urandom_range(0, 11) == 0,
              2'($urandom_range(0, 3)), "rnd");
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
